// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding, default widths and delay_cfg slicing helper
package reset_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    DELAY,
    WAIT_ACK,
    DONE,
    FAULT
  } state_t;

  localparam int DEF_CNT_W = 26;

  function automatic int stage_lsb(input int s, input int w);
    return s * w;
  endfunction

endpackage

// File: rtl/rst_delay_cnt.sv
// rst_delay_cnt: saturating up-counter with synchronous clear and a cnt >= limit flag
module rst_delay_cnt
  import reset_seq_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         hit
);

  logic [W-1:0] cnt;

  // count while enabled, hold at all-ones, clear whenever the owning phase is inactive
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + W'(1);
  end

  assign hit = cnt >= limit;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases N domain resets in order after PLL lock, with per-stage delay and ack timeout
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_STAGE = 4,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     locked,
  input  logic [N_STAGE*CNT_W-1:0] delay_cfg,
  input  logic [N_STAGE-1:0]       ack,
  input  logic                     soft_req,
  output logic [N_STAGE-1:0]       rst_n_out,
  output logic                     busy,
  output logic                     done,
  output logic                     fault,
  output logic [2:0]               fault_stage
);

  localparam int SW = N_STAGE > 1 ? $clog2(N_STAGE) : 1;
  localparam logic [SW-1:0] LAST = SW'(N_STAGE - 1);
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT - 1);

  state_t          state;
  logic [SW-1:0]   stage;
  logic [CNT_W-1:0] dly_lim;
  logic            dly_hit;
  logic            tmo_hit;
  logic            restart;

  assign dly_lim = delay_cfg[stage_lsb(int'(stage), CNT_W) +: CNT_W];

  // lock loss while sequencing/done, or a soft request once finished, drops every domain together
  assign restart = (!locked && (state == DELAY || state == WAIT_ACK || state == DONE)) ||
                   (soft_req && (state == DONE || state == FAULT));

  rst_delay_cnt #(.W(CNT_W)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != DELAY),
    .en   (state == DELAY),
    .limit(dly_lim),
    .hit  (dly_hit)
  );

  rst_delay_cnt #(.W(CNT_W)) u_tmo (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != WAIT_ACK),
    .en   (state == WAIT_ACK),
    .limit(TMO_LIM),
    .hit  (tmo_hit)
  );

  // sequencing FSM with registered outputs; ack beats timeout, restart beats both
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_LOCK;
      stage       <= '0;
      rst_n_out   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= '0;
    end else if (restart) begin
      state     <= WAIT_LOCK;
      rst_n_out <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          busy      <= 1'b1;
          rst_n_out <= '0;
          if (locked) begin
            state <= DELAY;
            stage <= '0;
          end
        end
        DELAY: begin
          if (dly_hit) begin
            rst_n_out[stage] <= 1'b1;
            state            <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack[stage]) begin
            if (stage == LAST) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              stage <= stage + SW'(1);
              state <= DELAY;
            end
          end else if (tmo_hit) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_stage <= 3'(stage);
            rst_n_out   <= '0;
            busy        <= 1'b0;
          end
        end
        DONE:    state <= DONE;
        FAULT:   state <= FAULT;
        default: state <= WAIT_LOCK;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: timeline-model scoreboard bench for reset_sequencer
module tb_reset_sequencer;

  localparam int N  = 3;
  localparam int CW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            locked = 1'b0;
  logic            soft_req = 1'b0;
  logic [N*CW-1:0] delay_cfg = '0;
  logic [N-1:0]    ack = '0;
  logic [N-1:0]    rst_n_out;
  logic            busy, done, fault;
  logic [2:0]      fault_stage;

  reset_sequencer #(.N_STAGE(N), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .locked     (locked),
    .delay_cfg  (delay_cfg),
    .ack        (ack),
    .soft_req   (soft_req),
    .rst_n_out  (rst_n_out),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .fault_stage(fault_stage)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  eno;
    logic [N-1:0] rn;
    logic         b;
    logic         d;
    logic         f;
    logic [2:0]   fs;
  } exp_t;

  exp_t       q[$];
  exp_t       m;
  int         checks = 0;
  int         errors = 0;
  int         eno = 0;
  logic [2:0] fs_m = '0;
  int         dv[N];
  int         av[N];

  // monitor: one expected entry per clock edge, compared away from the edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m = q.pop_front();
      checks++;
      if (rst_n_out !== m.rn || busy !== m.b || done !== m.d || fault !== m.f || fault_stage !== m.fs) begin
        errors++;
        $display("FAIL edge %0d: got rst_n_out=%b busy=%b done=%b fault=%b fault_stage=%0d, want %b %b %b %b %0d",
                 m.eno, rst_n_out, busy, done, fault, fault_stage, m.rn, m.b, m.d, m.f, m.fs);
      end
    end
  end

  task automatic step(input logic r, input logic l, input logic [N-1:0] a, input logic s,
                      input logic [N-1:0] rn, input logic b, input logic d, input logic f);
    exp_t e;
    rst = r; locked = l; ack = a; soft_req = s;
    e.eno = 32'(eno); e.rn = rn; e.b = b; e.d = d; e.f = f; e.fs = fs_m;
    q.push_back(e);
    eno++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [N-1:0] rack();
    return N'($urandom_range(0, (1 << N) - 1));
  endfunction

  // term: 0 lock drop, 1 soft_req, 2 rst; tsel >=0 edge offset, -1 end+3, -2 stage N-1 WAIT_ACK, -3 stage 1 DELAY
  task automatic run(input int term_in, input int tsel);
    int L, ent, ft, fst, endt, T, term, k;
    int rel[N], cmp[N];
    bit flt;
    logic [N-1:0] a, rn;
    logic l, s;
    term = term_in;
    for (int j = 0; j < N; j++) delay_cfg[j*CW +: CW] = CW'(dv[j]);
    L = $urandom_range(0, 3);
    for (int i = 0; i < L; i++) step(1'b0, 1'b0, rack(), rbit(), '0, 1'b1, 1'b0, 1'b0);
    ent = 0; flt = 0; ft = 0; fst = 0;
    for (int j = 0; j < N; j++) begin rel[j] = 1 << 20; cmp[j] = 1 << 20; end
    for (int j = 0; j < N && !flt; j++) begin
      rel[j] = ent + dv[j] + 1;
      if (av[j] >= TO) begin flt = 1; ft = rel[j] + TO; fst = j; end
      else begin cmp[j] = rel[j] + 1 + av[j]; ent = cmp[j]; end
    end
    endt = flt ? ft : cmp[N-1];
    T = tsel >= 0 ? tsel : tsel == -1 ? endt + 3 : tsel == -2 ? rel[N-1] + 1 : cmp[0] + 1;
    if (T < 1) T = 1;
    if (term == 0 && flt && T > ft) term = 1;
    if (term == 1 && T <= endt) T = endt + 1;
    for (int t = 0; t <= T; t++) begin
      l = (flt && t > ft) ? rbit() : 1'b1;
      s = t < endt ? rbit() : 1'b0;
      a = rack();
      for (int j = 0; j < N; j++) begin
        if (t > rel[j] && t < ((flt && j == fst) ? ft + 1 : cmp[j])) a[j] = 1'b0;
        if (t == cmp[j]) a[j] = 1'b1;
      end
      if (t < T) begin
        for (int j = 0; j < N; j++) rn[j] = t >= rel[j] && !(flt && t >= ft);
        if (flt && t == ft) fs_m = 3'(fst);
        step(1'b0, l, a, s, rn, t < endt, !flt && t >= endt, flt && t >= ft);
      end else if (term == 0) begin
        step(1'b0, 1'b0, a, s, '0, 1'b1, 1'b0, 1'b0);
      end else if (term == 1) begin
        step(1'b0, rbit(), a, 1'b1, '0, 1'b1, 1'b0, 1'b0);
      end else begin
        fs_m = '0;
        step(1'b1, rbit(), a, rbit(), '0, 1'b0, 1'b0, 1'b0);
        k = $urandom_range(0, 2);
        for (int i = 0; i < k; i++) step(1'b1, rbit(), rack(), rbit(), '0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  function automatic int rnd_ack();
    int r;
    r = $urandom_range(0, 9);
    return r < 6 ? int'($urandom_range(0, 4)) : r == 6 ? 15 : r == 7 ? 14 : r == 8 ? int'($urandom_range(5, 10)) : 99;
  endfunction

  initial begin
    #1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    dv = '{5, 0, 10}; av = '{0, 0, 0};  run(1, -1);
    dv = '{2, 3, 1};  av = '{0, 7, 2};  run(0, -2);
    dv = '{1, 1, 1};  av = '{1, 15, 0}; run(0, -1);
    dv = '{0, 2, 3};  av = '{0, 99, 0}; run(1, -1);
    dv = '{1, 4, 2};  av = '{0, 0, 0};  run(2, -3);
    dv = '{1, 1, 1};  av = '{2, 0, 0};  run(0, 5);
    dv = '{0, 0, 0};  av = '{0, 0, 99}; run(2, -1);
    for (int r = 0; r < 40; r++) begin
      for (int j = 0; j < N; j++) begin dv[j] = $urandom_range(0, 8); av[j] = rnd_ack(); end
      run($urandom_range(0, 2), $urandom_range(0, 1) ? -1 : int'($urandom_range(1, 60)));
    end
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
